// File: rtl/fifo_framer_if.sv
// Bundle of the sample-FIFO read side, the byte-stream handshake and the framer status lines.
// master = framer side, slave = FIFO/host side.
interface fifo_framer_if #(
    parameter int DATAWIDTH = 16
);
    logic                 enable;
    logic [DATAWIDTH-1:0] fifo_rd_data;
    logic                 fifo_ne;
    logic                 fifo_re;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           seq;
    logic                 stall;
    logic                 frame_done;

    modport master (
        input  enable, fifo_rd_data, fifo_ne, out_ready,
        output fifo_re, out_data, out_valid, seq, stall, frame_done
    );

    modport slave (
        output enable, fifo_rd_data, fifo_ne, out_ready,
        input  fifo_re, out_data, out_valid, seq, stall, frame_done
    );
endinterface

// File: rtl/fifo_framer.sv
// Pops FRAME_WORDS sample words and serialises them MSB-first as HDR, SEQ, payload[, CSUM].
// Define FIFO_FRAMER_CSUM_EN to append the trailing checksum byte.
module fifo_framer #(
    parameter int         DATAWIDTH   = 16,
    parameter int         FRAME_WORDS = 8,
    parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    fifo_framer_if.master bus
);
    localparam int BPW = DATAWIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

`ifdef FIFO_FRAMER_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_LOAD, S_DATA, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_LOAD, S_DATA} state_t;
`endif

    state_t               r_state, w_state_next;
    logic [7:0]           r_out_data, w_out_data_next;
    logic                 r_out_valid, w_out_valid_next;
    logic [7:0]           r_seq, w_seq_next;
    logic                 r_stall, w_stall_next;
    logic                 r_frame_done, w_frame_done_next;
    logic [WCW-1:0]       r_word_cnt, w_word_cnt_next;
    logic [BCW-1:0]       r_byte_cnt, w_byte_cnt_next;
    logic [DATAWIDTH-1:0] r_shift, w_shift_next;
`ifdef FIFO_FRAMER_CSUM_EN
    logic [7:0]           r_csum, w_csum_next;
`endif
    logic                 w_slot_free;
    logic                 w_fifo_re;

    // A new byte may be loaded when the output register is empty or being drained this cycle.
    assign w_slot_free = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next      = r_state;
        w_out_data_next   = r_out_data;
        w_out_valid_next  = w_slot_free ? 1'b0 : r_out_valid;
        w_seq_next        = r_seq;
        w_stall_next      = 1'b0;
        w_frame_done_next = 1'b0;
        w_word_cnt_next   = r_word_cnt;
        w_byte_cnt_next   = r_byte_cnt;
        w_shift_next      = r_shift;
        w_fifo_re         = 1'b0;
`ifdef FIFO_FRAMER_CSUM_EN
        w_csum_next       = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.enable && bus.fifo_ne) w_state_next = S_HDR;
            end
            S_HDR: begin
                if (w_slot_free) begin
                    w_out_data_next  = HDR_BYTE;
                    w_out_valid_next = 1'b1;
`ifdef FIFO_FRAMER_CSUM_EN
                    w_csum_next      = 8'd0;
`endif
                    w_state_next     = S_SEQ;
                end
            end
            S_SEQ: begin
                if (w_slot_free) begin
                    w_out_data_next  = r_seq;
                    w_out_valid_next = 1'b1;
`ifdef FIFO_FRAMER_CSUM_EN
                    w_csum_next      = r_seq;
`endif
                    w_state_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                // Pop and capture share the cycle: rd_data is already the registered head word.
                if (bus.fifo_ne) begin
                    w_fifo_re       = 1'b1;
                    w_shift_next    = bus.fifo_rd_data;
                    w_byte_cnt_next = '0;
                    w_state_next    = S_DATA;
                end else begin
                    w_stall_next    = 1'b1;
                end
            end
            S_DATA: begin
                if (w_slot_free) begin
                    w_out_data_next  = r_shift[DATAWIDTH-1 -: 8];
                    w_out_valid_next = 1'b1;
`ifdef FIFO_FRAMER_CSUM_EN
                    w_csum_next      = r_csum + r_shift[DATAWIDTH-1 -: 8];
`endif
                    w_shift_next     = r_shift << 8;
                    if (r_byte_cnt == BCW'(BPW - 1)) begin
                        if (r_word_cnt == WCW'(FRAME_WORDS - 1)) begin
                            w_word_cnt_next   = '0;
`ifdef FIFO_FRAMER_CSUM_EN
                            w_state_next      = S_CSUM;
`else
                            w_seq_next        = r_seq + 8'd1;
                            w_frame_done_next = 1'b1;
                            w_state_next      = S_IDLE;
`endif
                        end else begin
                            w_word_cnt_next = r_word_cnt + 1'b1;
                            w_state_next    = S_LOAD;
                        end
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 1'b1;
                    end
                end
            end
`ifdef FIFO_FRAMER_CSUM_EN
            S_CSUM: begin
                if (w_slot_free) begin
                    w_out_data_next   = r_csum;
                    w_out_valid_next  = 1'b1;
                    w_seq_next        = r_seq + 8'd1;
                    w_frame_done_next = 1'b1;
                    w_state_next      = S_IDLE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data   <= 8'd0;
            r_out_valid  <= 1'b0;
            r_seq        <= 8'd0;
            r_stall      <= 1'b0;
            r_frame_done <= 1'b0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
`ifdef FIFO_FRAMER_CSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_out_data   <= w_out_data_next;
            r_out_valid  <= w_out_valid_next;
            r_seq        <= w_seq_next;
            r_stall      <= w_stall_next;
            r_frame_done <= w_frame_done_next;
            r_word_cnt   <= w_word_cnt_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_shift      <= w_shift_next;
`ifdef FIFO_FRAMER_CSUM_EN
            r_csum       <= w_csum_next;
`endif
        end
    end

    assign bus.fifo_re    = w_fifo_re;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.seq        = r_seq;
    assign bus.stall      = r_stall;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_fifo_framer.sv
// Directed bench for fifo_framer: upstream FIFO model, byte monitor, hand-computed frames.
// Works with or without FIFO_FRAMER_CSUM_EN defined.
`timescale 1ns/1ps
module tb_fifo_framer;
`ifdef FIFO_FRAMER_CSUM_EN
    localparam int FLEN = 19;
`else
    localparam int FLEN = 18;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    fifo_framer_if #(.DATAWIDTH(16)) bus();

    fifo_framer #(.DATAWIDTH(16), .FRAME_WORDS(8), .HDR_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] fmem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          underflow = 0;
    logic [7:0]  rx_q [$];
    int          rx_t [$];
    int          cyc_cnt = 0;
    int          re_cnt = 0;
    int          fd_cnt = 0;
    logic [7:0]  fd_last = 8'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  t1_exp [0:18];

    // Upstream FIFO with registered head/ne; flushed while reset is high.
    always @(posedge clk) begin
        if (reset) rd_ptr = wr_ptr;
        else if (bus.fifo_re) begin
            if (rd_ptr == wr_ptr) underflow++;
            else rd_ptr++;
        end
        bus.fifo_ne      <= (rd_ptr != wr_ptr);
        bus.fifo_rd_data <= fmem[rd_ptr];
    end

    // Byte/handshake monitor sampling pre-edge values.
    always @(posedge clk) begin
        cyc_cnt++;
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                rx_q.push_back(bus.out_data);
                rx_t.push_back(cyc_cnt);
            end
            if (bus.fifo_re) re_cnt++;
            if (bus.frame_done) begin
                fd_cnt++;
                fd_last = bus.out_data;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fmem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic push_t1(input int first, input int count);
        for (int i = first; i < first + count; i++)
            push_word(16'h0102 + 16'(i) * 16'h0202);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Drive out_ready each cycle until 'target' bytes have been accepted; checks hold on back-pressure.
    task automatic wait_bytes(input int target, input bit toggle, input int budget);
        int cyc;
        logic pv, pr;
        logic [7:0] pd;
        cyc = 0; pv = 1'b0; pr = 1'b1; pd = 8'd0;
        while (rx_q.size() < target && cyc < budget) begin
            @(negedge clk);
            if (pv && !pr) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, pd);
            end
            pv = bus.out_valid;
            pd = bus.out_data;
            pr = toggle ? ~bus.out_ready : 1'b1;
            bus.out_ready = pr;
            cyc++;
        end
        bus.out_ready = 1'b1;
        check("byte_budget", rx_q.size() >= target, 1);
    endtask

    task automatic compare_table(input string tag, input int rxb);
        for (int i = 0; i < FLEN; i++)
            check($sformatf("%s[%0d]", tag, i), rx_q[rxb + i], t1_exp[i]);
    endtask

    // Expected frame from the FIFO contents: header, seq, MSB-first payload, sum of seq+payload.
    task automatic compare_frame(input string tag, input int rxb, input logic [7:0] s, input int mb);
        logic [7:0] cs, b;
        cs = s;
        check({tag, "_hdr"}, rx_q[rxb], 8'hA5);
        check({tag, "_seq"}, rx_q[rxb + 1], s);
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 2; k++) begin
                b = (k == 0) ? fmem[mb + w][15:8] : fmem[mb + w][7:0];
                cs = cs + b;
                check($sformatf("%s_pay%0d", tag, 2 * w + k), rx_q[rxb + 2 + 2 * w + k], b);
            end
        end
`ifdef FIFO_FRAMER_CSUM_EN
        check({tag, "_csum"}, rx_q[rxb + 18], cs);
`endif
    endtask

    initial begin
        int b, rb, fb, mb, i;
        t1_exp = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h88};
        bus.enable = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_seq", bus.seq, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_re", bus.fifo_re, 0);

        // Single frame, latency, counts
        do_reset();
        push_t1(0, 8);
        repeat (3) @(negedge clk);
        check("idle_no_start", bus.out_valid, 0);
        b = rx_q.size(); rb = re_cnt; fb = fd_cnt;
        bus.enable = 1'b1;
        @(negedge clk);
        check("lat1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat2_valid", bus.out_valid, 1);
        check("lat2_data", bus.out_data, 8'hA5);
        bus.enable = 1'b0;
        wait_bytes(b + FLEN, 1'b0, 200);
        repeat (6) @(negedge clk);
        compare_table("t1", b);
        check("t1_len", rx_q.size() - b, FLEN);
        check("t1_fd_cnt", fd_cnt - fb, 1);
        check("t1_fd_byte", fd_last, t1_exp[FLEN - 1]);
        check("t1_re_cnt", re_cnt - rb, 8);
        check("t1_seq", bus.seq, 1);

        // Two back-to-back frames
        do_reset();
        mb = wr_ptr;
        for (i = 0; i < 16; i++) push_word(16'hA000 + 16'(i) * 16'h0111);
        repeat (2) @(negedge clk);
        b = rx_q.size(); rb = re_cnt;
        bus.enable = 1'b1;
        wait_bytes(b + 2 * FLEN, 1'b0, 300);
        bus.enable = 1'b0;
        repeat (6) @(negedge clk);
        compare_frame("t2f0", b, 8'h00, mb);
        compare_frame("t2f1", b + FLEN, 8'h01, mb + 8);
        check("t2_len", rx_q.size() - b, 2 * FLEN);
        check("t2_re_cnt", re_cnt - rb, 16);
        check("t2_gap", rx_t[b + FLEN] - rx_t[b + FLEN - 1], 2);
        check("t2_hdr_seq_gap", rx_t[b + 1] - rx_t[b], 1);
        check("t2_load_bubble", rx_t[b + 2] - rx_t[b + 1], 2);
        check("t2_word_stream", rx_t[b + 3] - rx_t[b + 2], 1);
        check("t2_seq", bus.seq, 2);

        // Reset mid-frame from seq=2
        b = rx_q.size();
        push_t1(0, 8);
        bus.enable = 1'b1;
        wait_bytes(b + 3, 1'b0, 100);
        check("t6_pre_valid", bus.out_valid, 1);
        check("t6_pre_seq", bus.seq, 2);
        reset = 1'b1;
        #1;
        check("t6_async_valid", bus.out_valid, 0);
        check("t6_async_seq", bus.seq, 0);
        check("t6_async_data", bus.out_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        b = rx_q.size();
        push_t1(0, 8);
        wait_bytes(b + FLEN, 1'b0, 200);
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        compare_table("t6", b);

        // Toggling out_ready
        do_reset();
        push_t1(0, 8);
        repeat (2) @(negedge clk);
        b = rx_q.size();
        bus.enable = 1'b1;
        wait_bytes(b + FLEN, 1'b1, 400);
        bus.enable = 1'b0;
        repeat (6) @(negedge clk);
        compare_table("t3", b);
        check("t3_len", rx_q.size() - b, FLEN);

        // Upstream runs dry mid-frame
        do_reset();
        push_t1(0, 3);
        repeat (2) @(negedge clk);
        b = rx_q.size(); rb = re_cnt;
        bus.enable = 1'b1;
        for (i = 0; i < 60 && !bus.stall; i++) @(negedge clk);
        check("t4_stall", bus.stall, 1);
        check("t4_re_low", bus.fifo_re, 0);
        check("t4_ne_low", bus.fifo_ne, 0);
        repeat (5) @(negedge clk);
        check("t4_stall_hold", bus.stall, 1);
        check("t4_re_hold", bus.fifo_re, 0);
        check("t4_pops", re_cnt - rb, 3);
        check("t4_bytes_so_far", rx_q.size() - b, 8);
        push_t1(3, 5);
        wait_bytes(b + FLEN, 1'b0, 200);
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        compare_table("t4", b);
        check("t4_stall_clear", bus.stall, 0);

        // 256 frames: seq wraps FF -> 00
        do_reset();
        mb = wr_ptr;
        for (i = 0; i < 2048; i++) push_word(16'(i * 3));
        repeat (2) @(negedge clk);
        b = rx_q.size(); fb = fd_cnt;
        bus.enable = 1'b1;
        wait_bytes(b + 256 * FLEN, 1'b0, 12000);
        bus.enable = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_fd_cnt", fd_cnt - fb, 256);
        check("t5_seq_fe", rx_q[b + 254 * FLEN + 1], 8'hFE);
        compare_frame("t5_last", b + 255 * FLEN, 8'hFF, mb + 255 * 8);
        check("t5_seq_wrap", bus.seq, 0);

        check("no_underflow", underflow, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
